// File: rtl/elem_env_player.sv
// rtl/elem_env_player.sv - per-element envelope player: command latch, envelope fetch, amplitude scaling
module elem_env_player #(
    parameter int ENV_ADDR_WIDTH = 12,
    parameter int ENV_RD_LAT     = 3,
    parameter int AMP_WIDTH      = 16,
    parameter int FREQ_WIDTH     = 9,
    parameter int PHASE_WIDTH    = 17,
    parameter int MODE_WIDTH     = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmdstb,
    input  logic [ENV_ADDR_WIDTH-1:0] envstart,
    input  logic [ENV_ADDR_WIDTH-1:0] envlength,
    input  logic [AMP_WIDTH-1:0]      ampx,
    input  logic [FREQ_WIDTH-1:0]     freqaddr,
    input  logic [PHASE_WIDTH-1:0]    pini,
    input  logic [MODE_WIDTH-1:0]     mode,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun,
    output logic [ENV_ADDR_WIDTH-1:0] env_addr,
    output logic                      env_rden,
    input  logic [31:0]               env_rdata,
    output logic                      out_valid,
    output logic [15:0]               out_i,
    output logic [15:0]               out_q,
    output logic                      out_first,
    output logic                      out_last,
    output logic [FREQ_WIDTH-1:0]     out_freqaddr,
    output logic [PHASE_WIDTH-1:0]    out_pini,
    output logic [MODE_WIDTH-1:0]     out_mode
);

    localparam int PROD_WIDTH = 16 + AMP_WIDTH;
    localparam logic [ENV_ADDR_WIDTH-1:0] ADDR_ONE = {{(ENV_ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_t;

    state_t                     state;
    logic [ENV_ADDR_WIDTH-1:0]  remaining;
    logic                       env_first;
    logic                       env_last;
    logic [AMP_WIDTH-1:0]       amp_r;

    logic [ENV_RD_LAT-1:0]      vld_pipe;
    logic [ENV_RD_LAT-1:0]      first_pipe;
    logic [ENV_RD_LAT-1:0]      last_pipe;

    logic                       mul_valid;
    logic                       mul_first;
    logic                       mul_last;
    logic signed [PROD_WIDTH-1:0] mul_i;
    logic signed [PROD_WIDTH-1:0] mul_q;
    logic signed [PROD_WIDTH-1:0] i_ext;
    logic signed [PROD_WIDTH-1:0] q_ext;
    logic signed [PROD_WIDTH-1:0] amp_ext;

    // Sign-extend the envelope halves and zero-extend the gain so one signed multiply covers both
    always_comb begin
        i_ext    = {{AMP_WIDTH{env_rdata[15]}}, env_rdata[15:0]};
        q_ext    = {{AMP_WIDTH{env_rdata[31]}}, env_rdata[31:16]};
        amp_ext  = {16'b0, amp_r};
        env_last = env_rden && (remaining == ADDR_ONE);
    end

    // Command FSM: accepts in IDLE, issues one read per PLAY cycle, waits in DRAIN for the last sample
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            overrun      <= 1'b0;
            env_rden     <= 1'b0;
            env_addr     <= '0;
            remaining    <= '0;
            env_first    <= 1'b0;
            amp_r        <= '0;
            out_freqaddr <= '0;
            out_pini     <= '0;
            out_mode     <= '0;
        end else begin
            done <= 1'b0;
            if (cmdstb && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (cmdstb) begin
                        amp_r        <= ampx;
                        out_freqaddr <= freqaddr;
                        out_pini     <= pini;
                        out_mode     <= mode;
                        remaining    <= envlength;
                        if (envlength != '0) begin
                            state     <= PLAY;
                            busy      <= 1'b1;
                            env_rden  <= 1'b1;
                            env_addr  <= envstart;
                            env_first <= 1'b1;
                        end else begin
                            // Empty pulse: report completion without touching memory
                            done <= 1'b1;
                        end
                    end
                end
                PLAY: begin
                    env_first <= 1'b0;
                    if (remaining == ADDR_ONE) begin
                        env_rden <= 1'b0;
                        state    <= DRAIN;
                    end else begin
                        env_addr  <= env_addr + ADDR_ONE;
                        remaining <= remaining - ADDR_ONE;
                    end
                end
                DRAIN: begin
                    if (out_valid && out_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read-valid delay line, two-stage scaling pipeline and sample tagging
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe   <= '0;
            first_pipe <= '0;
            last_pipe  <= '0;
            mul_valid  <= 1'b0;
            mul_first  <= 1'b0;
            mul_last   <= 1'b0;
            mul_i      <= '0;
            mul_q      <= '0;
            out_valid  <= 1'b0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
            out_i      <= '0;
            out_q      <= '0;
        end else begin
            vld_pipe[0]   <= env_rden;
            first_pipe[0] <= env_rden && env_first;
            last_pipe[0]  <= env_last;
            for (int j = 1; j < ENV_RD_LAT; j++) begin
                vld_pipe[j]   <= vld_pipe[j-1];
                first_pipe[j] <= first_pipe[j-1];
                last_pipe[j]  <= last_pipe[j-1];
            end
            mul_valid <= vld_pipe[ENV_RD_LAT-1];
            mul_first <= first_pipe[ENV_RD_LAT-1];
            mul_last  <= last_pipe[ENV_RD_LAT-1];
            if (vld_pipe[ENV_RD_LAT-1]) begin
                mul_i <= i_ext * amp_ext;
                mul_q <= q_ext * amp_ext;
            end
            out_valid <= mul_valid;
            out_first <= mul_valid && mul_first;
            out_last  <= mul_valid && mul_last;
            // Arithmetic shift floors toward -inf; the result always fits 16 bits
            if (mul_valid) begin
                out_i <= 16'(mul_i >>> AMP_WIDTH);
                out_q <= 16'(mul_q >>> AMP_WIDTH);
            end
        end
    end

endmodule

// File: tb/tb_elem_env_player.sv
// tb/tb_elem_env_player.sv - randomized self-checking bench for elem_env_player
module tb_elem_env_player;

    localparam int LAT = 3;

    typedef logic [67:0] ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmdstb;
    logic [11:0] envstart;
    logic [11:0] envlength;
    logic [15:0] ampx;
    logic [8:0]  freqaddr;
    logic [16:0] pini;
    logic [1:0]  mode;
    logic        busy;
    logic        done;
    logic        overrun;
    logic [11:0] env_addr;
    logic        env_rden;
    logic [31:0] env_rdata;
    logic        out_valid;
    logic [15:0] out_i;
    logic [15:0] out_q;
    logic        out_first;
    logic        out_last;
    logic [8:0]  out_freqaddr;
    logic [16:0] out_pini;
    logic [1:0]  out_mode;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] mem [0:4095];
    logic [11:0] a_d1, a_d2;
    ev_t obs[$];
    ev_t exp_q[$];

    elem_env_player dut (
        .clk(clk), .reset(reset), .cmdstb(cmdstb), .envstart(envstart),
        .envlength(envlength), .ampx(ampx), .freqaddr(freqaddr), .pini(pini),
        .mode(mode), .busy(busy), .done(done), .overrun(overrun),
        .env_addr(env_addr), .env_rden(env_rden), .env_rdata(env_rdata),
        .out_valid(out_valid), .out_i(out_i), .out_q(out_q),
        .out_first(out_first), .out_last(out_last), .out_freqaddr(out_freqaddr),
        .out_pini(out_pini), .out_mode(out_mode)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Envelope memory with a fixed three-cycle read latency
    always @(posedge clk) begin
        a_d1      <= env_addr;
        a_d2      <= a_d1;
        env_rdata <= mem[a_d2];
    end

    function automatic ev_t mk(input int c, input int t, input logic f, input logic l,
                               input logic [31:0] p);
        return {32'(c), 2'(t), f, l, p};
    endfunction

    // Observed events: type 0 read, 1 sample, 2 done, 3 busy
    always @(negedge clk) begin
        if (env_rden)  obs.push_back(mk(cyc, 0, 1'b0, 1'b0, {20'b0, env_addr}));
        if (out_valid) obs.push_back(mk(cyc, 1, out_first, out_last, {out_q, out_i}));
        if (done)      obs.push_back(mk(cyc, 2, 1'b0, 1'b0, 32'b0));
        if (busy)      obs.push_back(mk(cyc, 3, 1'b0, 1'b0, 32'b0));
    end

    // Q0.16 gain with floor rounding, done with plain integer division
    function automatic logic [15:0] scale(input logic [15:0] x, input logic [15:0] a);
        longint p;
        longint d;
        p = longint'($signed(x)) * longint'(a);
        d = p / 65536;
        if (p < 0 && d * 65536 != p) d = d - 1;
        return d[15:0];
    endfunction

    // Expected event set for a command accepted with its strobe in cycle n
    task automatic expect_pulse(input int n, input logic [11:0] s, input int len,
                                input logic [15:0] a);
        logic [11:0] ad;
        logic [31:0] w;
        if (len == 0) begin
            exp_q.push_back(mk(n + 1, 2, 1'b0, 1'b0, 32'b0));
        end else begin
            for (int k = 0; k < len; k++) begin
                ad = s + 12'(k);
                w  = mem[ad];
                exp_q.push_back(mk(n + 1 + k, 0, 1'b0, 1'b0, {20'b0, ad}));
                exp_q.push_back(mk(n + 1 + k + LAT + 2, 1, k == 0, k == len - 1,
                                   {scale(w[31:16], a), scale(w[15:0], a)}));
            end
            for (int c = n + 1; c <= n + LAT + 2 + len; c++)
                exp_q.push_back(mk(c, 3, 1'b0, 1'b0, 32'b0));
            exp_q.push_back(mk(n + LAT + 3 + len, 2, 1'b0, 1'b0, 32'b0));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        obs.delete();
        exp_q.delete();
    endtask

    task automatic issue(input logic [11:0] s, input logic [11:0] l, input logic [15:0] a,
                         input logic [8:0] f, input logic [16:0] p, input logic [1:0] m,
                         output int n);
        envstart  = s;
        envlength = l;
        ampx      = a;
        freqaddr  = f;
        pini      = p;
        mode      = m;
        cmdstb    = 1'b1;
        n         = cyc;
        tick();
        cmdstb    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busy, done, overrun, env_rden, out_valid, out_first, out_last} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0", {busy, done, overrun, env_rden, out_valid, out_first, out_last});
        end
        checks++;
        if ({env_addr, out_i, out_q, out_freqaddr, out_pini, out_mode} !== 72'b0) begin
            errors++;
            $display("FAIL reset_fields got %h want 0", {env_addr, out_i, out_q, out_freqaddr, out_pini, out_mode});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int n;
        fill_mem();
        for (int i = 'h10; i < 'h14; i++) mem[i] = 32'h4000_4000;
        issue(12'h010, 12'd4, 16'h8000, 9'h055, 17'h1_2345, 2'd1, n);
        expect_pulse(n, 12'h010, 4, 16'h8000);
        wait_until(n + 16);
        obs.sort();
        exp_q.sort();
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL basic_count got %0d want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_event[%0d] got %h want %h", i, obs[i], exp_q[i]);
            end
        end
        checks++;
        if ({out_freqaddr, out_pini, out_mode} !== {9'h055, 17'h1_2345, 2'd1}) begin
            errors++;
            $display("FAIL basic_tags got %h want %h", {out_freqaddr, out_pini, out_mode}, {9'h055, 17'h1_2345, 2'd1});
        end
    endtask

    task automatic test_wrap();
        int n;
        logic [15:0] a;
        fill_mem();
        a = 16'($urandom);
        issue(12'hFFE, 12'd4, a, 9'h1A0, 17'h0_0F0F, 2'd2, n);
        expect_pulse(n, 12'hFFE, 4, a);
        wait_until(n + 16);
        obs.sort();
        exp_q.sort();
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL wrap_count got %0d want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL wrap_event[%0d] got %h want %h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_zero_length();
        int n;
        fill_mem();
        issue(12'h123, 12'd0, 16'h1234, 9'h0C3, 17'h1_FFFF, 2'd3, n);
        expect_pulse(n, 12'h123, 0, 16'h1234);
        wait_until(n + 12);
        obs.sort();
        exp_q.sort();
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL zero_count got %0d want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL zero_event[%0d] got %h want %h", i, obs[i], exp_q[i]);
            end
        end
        checks++;
        if ({out_freqaddr, out_pini, out_mode} !== {9'h0C3, 17'h1_FFFF, 2'd3}) begin
            errors++;
            $display("FAIL zero_tags got %h want %h", {out_freqaddr, out_pini, out_mode}, {9'h0C3, 17'h1_FFFF, 2'd3});
        end
    endtask

    task automatic test_single();
        int n;
        fill_mem();
        mem[12'h300] = 32'h0001_8000;
        issue(12'h300, 12'd1, 16'hFFFF, 9'h001, 17'h0_0001, 2'd0, n);
        expect_pulse(n, 12'h300, 1, 16'hFFFF);
        wait_until(n + 12);
        obs.sort();
        exp_q.sort();
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL single_count got %0d want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL single_event[%0d] got %h want %h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int n;
        int len;
        logic [11:0] s;
        logic [15:0] a;
        logic [8:0]  f;
        logic [16:0] p;
        logic [1:0]  m;
        for (int it = 0; it < 6; it++) begin
            fill_mem();
            s   = 12'($urandom);
            len = $urandom_range(1, 24);
            a   = 16'($urandom);
            f   = 9'($urandom);
            p   = 17'($urandom);
            m   = 2'($urandom);
            issue(s, 12'(len), a, f, p, m, n);
            expect_pulse(n, s, len, a);
            wait_until(n + len + 12);
            obs.sort();
            exp_q.sort();
            checks++;
            if (obs.size() != exp_q.size()) begin
                errors++;
                $display("FAIL random%0d_count got %0d want %0d", it, obs.size(), exp_q.size());
            end
            for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
                checks++;
                if (obs[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random%0d_event[%0d] got %h want %h", it, i, obs[i], exp_q[i]);
                end
            end
            checks++;
            if ({out_freqaddr, out_pini, out_mode} !== {f, p, m}) begin
                errors++;
                $display("FAIL random%0d_tags got %h want %h", it, {out_freqaddr, out_pini, out_mode}, {f, p, m});
            end
        end
    endtask

    task automatic test_overrun();
        int n;
        int n2;
        fill_mem();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_initial got %b want 0", overrun);
        end
        issue(12'h200, 12'd6, 16'h9ABC, 9'h011, 17'h0_1111, 2'd1, n);
        expect_pulse(n, 12'h200, 6, 16'h9ABC);
        wait_until(n + 3);
        envstart  = 12'h700;
        envlength = 12'd3;
        freqaddr  = 9'h1FF;
        cmdstb    = 1'b1;
        tick();
        cmdstb    = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_play got %b want 1", overrun);
        end
        // Final DRAIN cycle: the last sample is on the output this cycle
        wait_until(n + LAT + 2 + 6);
        envstart  = 12'h800;
        envlength = 12'd5;
        cmdstb    = 1'b1;
        tick();
        cmdstb    = 1'b0;
        // Now in the done cycle: this command must be accepted
        issue(12'h400, 12'd3, 16'h4321, 9'h0AA, 17'h1_0101, 2'd2, n2);
        expect_pulse(n2, 12'h400, 3, 16'h4321);
        wait_until(n2 + 16);
        obs.sort();
        exp_q.sort();
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL overrun_count got %0d want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL overrun_event[%0d] got %h want %h", i, obs[i], exp_q[i]);
            end
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky got %b want 1", overrun);
        end
        checks++;
        if (out_freqaddr !== 9'h0AA) begin
            errors++;
            $display("FAIL overrun_tag got %h want %h", out_freqaddr, 9'h0AA);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        fill_mem();
        issue(12'h0F0, 12'd8, 16'h7777, 9'h033, 17'h0_2222, 2'd3, n);
        for (int k = 0; k < 3; k++)
            exp_q.push_back(mk(n + 1 + k, 0, 1'b0, 1'b0, {20'b0, 12'h0F0 + 12'(k)}));
        for (int c = n + 1; c <= n + 3; c++)
            exp_q.push_back(mk(c, 3, 1'b0, 1'b0, 32'b0));
        wait_until(n + 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, done, overrun, env_rden, out_valid, out_first, out_last} !== 7'b0) begin
            errors++;
            $display("FAIL midreset_flags got %b want 0", {busy, done, overrun, env_rden, out_valid, out_first, out_last});
        end
        checks++;
        if ({env_addr, out_i, out_q, out_freqaddr, out_pini, out_mode} !== 72'b0) begin
            errors++;
            $display("FAIL midreset_fields got %h want 0", {env_addr, out_i, out_q, out_freqaddr, out_pini, out_mode});
        end
        wait_until(n + 20);
        issue(12'h050, 12'd3, 16'hC000, 9'h0F0, 17'h0_0ABC, 2'd1, n);
        expect_pulse(n, 12'h050, 3, 16'hC000);
        wait_until(n + 16);
        obs.sort();
        exp_q.sort();
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL midreset_count got %0d want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL midreset_event[%0d] got %h want %h", i, obs[i], exp_q[i]);
            end
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL midreset_overrun got %b want 0", overrun);
        end
    endtask

    initial begin
        reset     = 1'b1;
        cmdstb    = 1'b0;
        envstart  = '0;
        envlength = '0;
        ampx      = '0;
        freqaddr  = '0;
        pini      = '0;
        mode      = '0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_zero_length();
        test_single();
        test_random();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
